// File: rtl/sr_pkg.sv
// -----------------------------------------------------------------------------
// sr_pkg -- shared definitions for the SR flip-flop drive controller.
//
// Contents:
//   sr_state_e           FSM state encoding used by sr_drive_ctrl
//   SR_DEBOUNCE_CYC_DEF  default number of consecutive high samples to accept
//   SR_PULSE_CYC_DEF     default width of the active-low command pulse
//   SR_CNT_W             width of the FSM counter and the press counters
//   sr_sat_inc8()        8-bit saturating increment (press counters)
// -----------------------------------------------------------------------------
package sr_pkg;

    localparam int SR_DEBOUNCE_CYC_DEF = 4;
    localparam int SR_PULSE_CYC_DEF    = 2;
    localparam int SR_CNT_W            = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DEB_SET = 3'd1,
        ST_DEB_CLR = 3'd2,
        ST_DRV_SET = 3'd3,
        ST_DRV_CLR = 3'd4,
        ST_GUARD   = 3'd5
    } sr_state_e;

    // Increment that sticks at 8'hFF instead of wrapping to zero.
    function automatic logic [SR_CNT_W-1:0] sr_sat_inc8(input logic [SR_CNT_W-1:0] v);
        sr_sat_inc8 = (v == {SR_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sr_drive_ctrl.sv
// -----------------------------------------------------------------------------
// sr_drive_ctrl -- debounces raw set/clear requests and issues one fixed-width
// active-low command pulse per accepted press to a downstream SR flip-flop.
//
// Parameters:
//   DEBOUNCE_CYC  consecutive high samples needed to accept a request (1..255)
//   PULSE_CYC     cycles the active-low command is held low           (1..255)
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   synchronous reset, active-high
//   set_req   in   raw set request, active-high, may bounce
//   clr_req   in   raw clear request, active-high, may bounce
//   s         out  active-low set command (registered, idle 1)
//   r         out  active-low reset command (registered, idle 1)
//   busy      out  high whenever the FSM is not IDLE (registered)
//   conflict  out  one-cycle pulse when both requests are seen together
//   state_o   out  current FSM state, for debug/observation
//   set_cnt   out  [7:0] saturating count of DRV_SET entries (SR_DRIVE_CNT_EN)
//   clr_cnt   out  [7:0] saturating count of DRV_CLR entries (SR_DRIVE_CNT_EN)
//
// Configuration macro: SR_DRIVE_CNT_EN adds the set_cnt/clr_cnt outputs and
// their counters; without it those ports and registers do not exist.
//
// Handshake: none. set_req/clr_req are level inputs sampled every rising edge;
// a press is one debounced high level, and GUARD requires both inputs to be
// seen low before another press can be accepted.
// -----------------------------------------------------------------------------
module sr_drive_ctrl
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYC = SR_DEBOUNCE_CYC_DEF,
    parameter int PULSE_CYC    = SR_PULSE_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_req,
    input  logic       clr_req,
    output logic       s,
    output logic       r,
    output logic       busy,
    output logic       conflict,
    output logic [2:0] state_o
`ifdef SR_DRIVE_CNT_EN
    ,
    output logic [7:0] set_cnt,
    output logic [7:0] clr_cnt
`endif
);

    localparam logic [SR_CNT_W-1:0] DEB_LAST = SR_CNT_W'(DEBOUNCE_CYC);
    localparam logic [SR_CNT_W-1:0] PUL_LAST = SR_CNT_W'(PULSE_CYC);

    sr_state_e           state_q, state_d;
    logic [SR_CNT_W-1:0] cnt_q, cnt_d;
    logic [SR_CNT_W-1:0] cnt_inc;
    logic                s_q, r_q, busy_q, conflict_q;
    logic                conflict_d;

    // cnt never exceeds 254 (it is cleared when it would reach a parameter
    // value of at most 255), so this increment cannot wrap.
    assign cnt_inc = cnt_q + 1'b1;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        conflict_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (set_req && clr_req) begin
                    state_d    = ST_GUARD;
                    cnt_d      = '0;
                    conflict_d = 1'b1;
                end else if (set_req) begin
                    // The IDLE sample is the first of the debounce window.
                    if (DEBOUNCE_CYC == 1) begin
                        state_d = ST_DRV_SET;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_DEB_SET;
                        cnt_d   = SR_CNT_W'(1);
                    end
                end else if (clr_req) begin
                    if (DEBOUNCE_CYC == 1) begin
                        state_d = ST_DRV_CLR;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_DEB_CLR;
                        cnt_d   = SR_CNT_W'(1);
                    end
                end
            end

            ST_DEB_SET: begin
                if (set_req && clr_req) begin
                    state_d    = ST_GUARD;
                    cnt_d      = '0;
                    conflict_d = 1'b1;
                end else if (set_req) begin
                    if (cnt_inc == DEB_LAST) begin
                        state_d = ST_DRV_SET;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            ST_DEB_CLR: begin
                if (set_req && clr_req) begin
                    state_d    = ST_GUARD;
                    cnt_d      = '0;
                    conflict_d = 1'b1;
                end else if (clr_req) begin
                    if (cnt_inc == DEB_LAST) begin
                        state_d = ST_DRV_CLR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            // Requests are ignored while driving; the pulse always completes.
            ST_DRV_SET, ST_DRV_CLR: begin
                if (cnt_inc == PUL_LAST) begin
                    state_d = ST_GUARD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_GUARD: begin
                if (!set_req && !clr_req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and registered outputs. Outputs are decoded from the next state
    // so a command goes low on the same edge that enters DRV_x, with no
    // combinational path from the inputs to s/r.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            s_q        <= 1'b1;
            r_q        <= 1'b1;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s_q        <= (state_d != ST_DRV_SET);
            r_q        <= (state_d != ST_DRV_CLR);
            busy_q     <= (state_d != ST_IDLE);
            conflict_q <= conflict_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;
    assign state_o  = state_q;

`ifdef SR_DRIVE_CNT_EN
    // -------------------------------------------------------------------------
    // Press counters: count entries into each drive state, saturating at 255.
    // -------------------------------------------------------------------------
    logic [7:0] set_cnt_q, clr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            set_cnt_q <= '0;
            clr_cnt_q <= '0;
        end else begin
            if (state_d == ST_DRV_SET && state_q != ST_DRV_SET) begin
                set_cnt_q <= sr_sat_inc8(set_cnt_q);
            end
            if (state_d == ST_DRV_CLR && state_q != ST_DRV_CLR) begin
                clr_cnt_q <= sr_sat_inc8(clr_cnt_q);
            end
        end
    end

    assign set_cnt = set_cnt_q;
    assign clr_cnt = clr_cnt_q;
`endif

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sr_drive_ctrl -- directed bench for sr_drive_ctrl with DEBOUNCE_CYC=4 and
// PULSE_CYC=2. Inputs change 1 ns after a rising edge, outputs are sampled at
// the same point, so each "edge k" below is the k-th rising edge after the
// stimulus was applied.
// -----------------------------------------------------------------------------
module tb_sr_drive_ctrl;
    import sr_pkg::*;

    localparam int DEB = 4;
    localparam int PUL = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       set_req;
    logic       clr_req;
    logic       s;
    logic       r;
    logic       busy;
    logic       conflict;
    logic [2:0] state_o;
`ifdef SR_DRIVE_CNT_EN
    logic [7:0] set_cnt;
    logic [7:0] clr_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    sr_drive_ctrl #(
        .DEBOUNCE_CYC(DEB),
        .PULSE_CYC   (PUL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .set_req (set_req),
        .clr_req (clr_req),
        .s       (s),
        .r       (r),
        .busy    (busy),
        .conflict(conflict),
        .state_o (state_o)
`ifdef SR_DRIVE_CNT_EN
        ,
        .set_cnt (set_cnt),
        .clr_cnt (clr_cnt)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        set_req = 1'b0;
        clr_req = 1'b0;
        step();
        step();
        rst = 1'b0;
        n_tests++; if (s !== 1'b1)        begin n_fail++; $display("FAIL reset_s got=%b exp=1", s); end
        n_tests++; if (r !== 1'b1)        begin n_fail++; $display("FAIL reset_r got=%b exp=1", r); end
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict got=%b exp=0", conflict); end
        n_tests++; if (state_o !== 3'd0)  begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        step();
        n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    // set_req high for 10 edges: s low after edges 4 and 5, busy clears on
    // the edge that sees set_req low (edge 11).
    task automatic test_set_press();
        logic s_exp, busy_exp;
        set_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            s_exp    = (k >= DEB && k < DEB + PUL) ? 1'b0 : 1'b1;
            busy_exp = (k <= 10) ? 1'b1 : 1'b0;
            n_tests++; if (s !== s_exp)       begin n_fail++; $display("FAIL set_press_s k=%0d got=%b exp=%b", k, s, s_exp); end
            n_tests++; if (r !== 1'b1)        begin n_fail++; $display("FAIL set_press_r k=%0d got=%b exp=1", k, r); end
            n_tests++; if (busy !== busy_exp) begin n_fail++; $display("FAIL set_press_busy k=%0d got=%b exp=%b", k, busy, busy_exp); end
            n_tests++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL set_press_conflict k=%0d got=%b exp=0", k, conflict); end
            if (k == 10) set_req = 1'b0;
        end
    endtask

    // clr_req high on edges 1-3, low on 4, high on 5-10: the first burst is
    // rejected, the second accepted on edge 8 (4th sample), r low after 8, 9.
    task automatic test_clr_bounce();
        logic r_exp, busy_exp;
        for (int k = 1; k <= 13; k++) begin
            clr_req  = (k <= 3 || (k >= 5 && k <= 10)) ? 1'b1 : 1'b0;
            step();
            r_exp    = (k == 8 || k == 9) ? 1'b0 : 1'b1;
            busy_exp = (k <= 3 || (k >= 5 && k <= 10)) ? 1'b1 : 1'b0;
            n_tests++; if (r !== r_exp)       begin n_fail++; $display("FAIL clr_bounce_r k=%0d got=%b exp=%b", k, r, r_exp); end
            n_tests++; if (s !== 1'b1)        begin n_fail++; $display("FAIL clr_bounce_s k=%0d got=%b exp=1", k, s); end
            n_tests++; if (busy !== busy_exp) begin n_fail++; $display("FAIL clr_bounce_busy k=%0d got=%b exp=%b", k, busy, busy_exp); end
        end
        clr_req = 1'b0;
    endtask

    // Both requests rise together and stay high for 3 edges.
    task automatic test_conflict();
        logic c_exp, busy_exp;
        for (int k = 1; k <= 6; k++) begin
            set_req  = (k <= 3) ? 1'b1 : 1'b0;
            clr_req  = (k <= 3) ? 1'b1 : 1'b0;
            step();
            c_exp    = (k == 1) ? 1'b1 : 1'b0;
            busy_exp = (k <= 3) ? 1'b1 : 1'b0;
            n_tests++; if (conflict !== c_exp) begin n_fail++; $display("FAIL conflict_pulse k=%0d got=%b exp=%b", k, conflict, c_exp); end
            n_tests++; if (s !== 1'b1)         begin n_fail++; $display("FAIL conflict_s k=%0d got=%b exp=1", k, s); end
            n_tests++; if (r !== 1'b1)         begin n_fail++; $display("FAIL conflict_r k=%0d got=%b exp=1", k, r); end
            n_tests++; if (busy !== busy_exp)  begin n_fail++; $display("FAIL conflict_busy k=%0d got=%b exp=%b", k, busy, busy_exp); end
        end
    endtask

    // Reset during the first cycle of s low truncates the pulse; a new press
    // then produces a fresh, full pulse.
    task automatic test_reset_mid_drive();
        set_req = 1'b1;
        for (int k = 1; k <= DEB; k++) step();
        n_tests++; if (s !== 1'b0) begin n_fail++; $display("FAIL mid_drive_s_low got=%b exp=0", s); end
        rst = 1'b1;
        step();
        rst     = 1'b0;
        set_req = 1'b0;
        n_tests++; if (s !== 1'b1)       begin n_fail++; $display("FAIL mid_drive_rst_s got=%b exp=1", s); end
        n_tests++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL mid_drive_rst_state got=%0d exp=0", state_o); end
        n_tests++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL mid_drive_rst_busy got=%b exp=0", busy); end
        for (int k = 1; k <= 6; k++) begin
            step();
            n_tests++; if (s !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_drive_quiet k=%0d s=%b busy=%b exp s=1 busy=0", k, s, busy); end
        end
        set_req = 1'b1;
        for (int k = 1; k <= DEB; k++) begin
            step();
            n_tests++;
            if (s !== ((k == DEB) ? 1'b0 : 1'b1)) begin
                n_fail++; $display("FAIL mid_drive_repress_s k=%0d got=%b exp=%b", k, s, (k == DEB) ? 1'b0 : 1'b1);
            end
        end
        set_req = 1'b0;
        for (int k = 1; k <= 4; k++) step();
        n_tests++; if (busy !== 1'b0 || s !== 1'b1) begin n_fail++; $display("FAIL mid_drive_final busy=%b s=%b exp busy=0 s=1", busy, s); end
    endtask

`ifdef SR_DRIVE_CNT_EN
    task automatic press(input logic is_set);
        if (is_set) set_req = 1'b1; else clr_req = 1'b1;
        for (int k = 1; k <= DEB; k++) step();
        set_req = 1'b0;
        clr_req = 1'b0;
        for (int k = 1; k <= PUL + 2; k++) step();
    endtask

    task automatic test_counts();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++; if (set_cnt !== 8'd0 || clr_cnt !== 8'd0) begin n_fail++; $display("FAIL cnt_reset set=%0d clr=%0d exp 0 0", set_cnt, clr_cnt); end
        for (int i = 0; i < 3; i++) press(1'b1);
        press(1'b0);
        n_tests++; if (set_cnt !== 8'd3) begin n_fail++; $display("FAIL cnt_set got=%0d exp=3", set_cnt); end
        n_tests++; if (clr_cnt !== 8'd1) begin n_fail++; $display("FAIL cnt_clr got=%0d exp=1", clr_cnt); end
        for (int i = 0; i < 300; i++) press(1'b1);
        n_tests++; if (set_cnt !== 8'd255) begin n_fail++; $display("FAIL cnt_sat got=%0d exp=255", set_cnt); end
        n_tests++; if (clr_cnt !== 8'd1)   begin n_fail++; $display("FAIL cnt_clr_hold got=%0d exp=1", clr_cnt); end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        set_req = 1'b0;
        clr_req = 1'b0;
        test_reset();
        test_set_press();
        test_clr_bounce();
        test_conflict();
        test_reset_mid_drive();
`ifdef SR_DRIVE_CNT_EN
        test_counts();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
